// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined logic unit.
package logic_unit_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOT  = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_XNOR = 3'b110,
      OP_PASS = 3'b111
   } op_t;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_core.sv
// Combinational bitwise evaluator: effective A, B and opcode to result.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_eff_i,
   input  logic [WIDTH-1:0] b_i,
   input  op_t              op_i,
   output logic [WIDTH-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_AND:  result_o = a_eff_i & b_i;
         OP_OR:   result_o = a_eff_i | b_i;
         OP_XOR:  result_o = a_eff_i ^ b_i;
         OP_NOT:  result_o = ~a_eff_i;
         OP_NAND: result_o = ~(a_eff_i & b_i);
         OP_NOR:  result_o = ~(a_eff_i | b_i);
         OP_XNOR: result_o = ~(a_eff_i ^ b_i);
         OP_PASS: result_o = b_i;
         default: result_o = '0;
      endcase
   end

endmodule : logic_unit_core

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit with accumulator operand and result flags.
// Define LOGIC_UNIT_POPCOUNT_EN to build the registered population count on out_popcnt.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic [OP_W-1:0]              op,
   input  logic                         acc_mode,
   input  logic                         acc_clr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_zero,
   output logic                         out_parity,
   output logic [$clog2(WIDTH+1)-1:0]   out_popcnt
);

   localparam int unsigned PC_W = $clog2(WIDTH + 1);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   op_t              s1_op_q, s1_op_d;
   logic             s1_acc_mode_q, s1_acc_mode_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s2_adv_c, s1_adv_c, s2_load_c;
   logic [WIDTH-1:0] a_eff_c, result_c;

   // Stall chain: no skid buffer, so in_ready follows out_ready combinationally.
   assign s2_adv_c  = !s2_valid_q || out_ready;
   assign s1_adv_c  = !s1_valid_q || s2_adv_c;
   assign s2_load_c = s2_adv_c && s1_valid_q;
   assign in_ready  = s1_adv_c && !rst;

   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_a_d        = s1_a_q;
      s1_b_d        = s1_b_q;
      s1_op_d       = s1_op_q;
      s1_acc_mode_d = s1_acc_mode_q;
      if (s1_adv_c) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d        = a;
            s1_b_d        = b;
            s1_op_d       = op_t'(op);
            s1_acc_mode_d = acc_mode;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_a_q        <= '0;
         s1_b_q        <= '0;
         s1_op_q       <= OP_AND;
         s1_acc_mode_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         s1_op_q       <= s1_op_d;
         s1_acc_mode_q <= s1_acc_mode_d;
      end
   end

   // Accumulator substitution happens at compute time so chained ops see the latest result.
   assign a_eff_c = s1_acc_mode_q ? acc_q : s1_a_q;

   logic_unit_core #(.WIDTH(WIDTH)) u_core (
      .a_eff_i  (a_eff_c),
      .b_i      (s1_b_q),
      .op_i     (s1_op_q),
      .result_o (result_c)
   );

   always_comb begin
      s2_valid_d = s2_valid_q;
      data_d     = data_q;
      zero_d     = zero_q;
      parity_d   = parity_q;
      acc_d      = acc_q;
      if (s2_adv_c) begin
         s2_valid_d = s1_valid_q;
      end
      if (s2_load_c) begin
         data_d   = result_c;
         zero_d   = (result_c == '0);
         parity_d = ^result_c;
         acc_d    = result_c;
      end
      // Clear wins over a same-cycle load; the loaded result still reaches out_data.
      if (acc_clr) begin
         acc_d = ACC_INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         data_q     <= '0;
         zero_q     <= 1'b0;
         parity_q   <= 1'b0;
         acc_q      <= ACC_INIT;
      end else begin
         s2_valid_q <= s2_valid_d;
         data_q     <= data_d;
         zero_q     <= zero_d;
         parity_q   <= parity_d;
         acc_q      <= acc_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_data   = data_q;
   assign out_zero   = zero_q;
   assign out_parity = parity_q;

`ifdef LOGIC_UNIT_POPCOUNT_EN
   logic [PC_W-1:0] popcnt_q, popcnt_d;

   always_comb begin
      popcnt_d = popcnt_q;
      if (s2_load_c) begin
         popcnt_d = '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            popcnt_d = popcnt_d + PC_W'(result_c[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         popcnt_q <= '0;
      end else begin
         popcnt_q <= popcnt_d;
      end
   end

   assign out_popcnt = popcnt_q;
`else
   assign out_popcnt = PC_W'(0);
`endif

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: randomized and directed traffic against a truth-table model.
module tb_logic_unit_pipe;

   localparam int unsigned W   = 8;
   localparam int unsigned PCW = $clog2(W + 1);
   localparam logic [W-1:0] ACC_INIT = 8'h00;

   logic           clk, rst, in_valid, in_ready, acc_mode, acc_clr;
   logic           out_valid, out_ready, out_zero, out_parity;
   logic [W-1:0]   a, b, out_data;
   logic [2:0]     op;
   logic [PCW-1:0] out_popcnt;

   logic_unit_pipe #(.WIDTH(W), .ACC_INIT(ACC_INIT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zero(out_zero), .out_parity(out_parity), .out_popcnt(out_popcnt)
   );

   typedef struct {
      logic [W-1:0]   data;
      logic           zero;
      logic           par;
      logic [PCW-1:0] pc;
      int             stamp;
      bit             lat;
   } exp_t;

   exp_t         q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           rnd_ready = 0;
   logic [W-1:0] acc_model;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Each result bit is the op's truth table indexed by {a_bit, b_bit}.
   function automatic logic [W-1:0] ref_res(input logic [2:0] fop, input logic [W-1:0] fa,
                                            input logic [W-1:0] fb);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (fop)
         3'd0: tt = 4'b1000;
         3'd1: tt = 4'b1110;
         3'd2: tt = 4'b0110;
         3'd3: tt = 4'b0011;
         3'd4: tt = 4'b0111;
         3'd5: tt = 4'b0001;
         3'd6: tt = 4'b1001;
         default: tt = 4'b1010;
      endcase
      for (int i = 0; i < int'(W); i++) r[i] = tt[{fa[i], fb[i]}];
      return r;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                       input logic tam, input int exp_res, input bit lat);
      exp_t         e;
      logic [W-1:0] r;
      int           n;
      a = ta; b = tb_; op = top; acc_mode = tam; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout in_ready stuck at 0 expected 1 (cycle %0d)", cyc);
      end else begin
         r = (exp_res >= 0) ? W'(exp_res) : ref_res(top, tam ? acc_model : ta, tb_);
         acc_model = r;
         e.data  = r;
         e.zero  = (r == '0);
         e.par   = ($countones(r) % 2) == 1;
`ifdef LOGIC_UNIT_POPCOUNT_EN
         e.pc    = PCW'($countones(r));
`else
         e.pc    = '0;
`endif
         e.stamp = cyc;
         e.lat   = lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_mode = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_pending", 32'(q.size()), 0);
   endtask

   task automatic clear_acc();
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      acc_model = ACC_INIT;
   endtask

   // Monitor: compare every output transfer against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got %0h with nothing expected (cycle %0d)", out_data, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("out_data",   32'(out_data),   32'(mon_e.data));
            chk("out_zero",   32'(out_zero),   32'(mon_e.zero));
            chk("out_parity", 32'(out_parity), 32'(mon_e.par));
            chk("out_popcnt", 32'(out_popcnt), 32'(mon_e.pc));
            if (mon_e.lat) chk("latency", 32'(cyc - mon_e.stamp), 2);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
   end

   logic [7:0] plan_res [8];

   initial begin
      plan_res = '{8'h00, 8'hFF, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'h00, 8'h3A};
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
      acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
      acc_model = ACC_INIT;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_reset", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",   32'(in_ready),   1);
      chk("rst_out_valid",  32'(out_valid),  0);
      chk("rst_out_data",   32'(out_data),   0);
      chk("rst_out_zero",   32'(out_zero),   0);
      chk("rst_out_parity", 32'(out_parity), 0);
      chk("rst_out_popcnt", 32'(out_popcnt), 0);
      @(posedge clk);
      #1;

      // All ops back-to-back, no stall
      for (int i = 0; i < 8; i++) send(8'hC5, 8'h3A, 3'(i), 1'b0, int'(plan_res[i]), 1'b1);
      drain();

      // Accumulator chain
      clear_acc();
      send(8'h00, 8'h0F, 3'd7, 1'b0, 8'h0F, 1'b1);
      send(8'h00, 8'hFF, 3'd2, 1'b1, 8'hF0, 1'b1);
      send(8'h00, 8'h3C, 3'd0, 1'b1, 8'h30, 1'b1);
      drain();

      // Stall: two accepted, third blocked, held output stable
      out_ready = 1'b0;
      send(8'h00, 8'h11, 3'd7, 1'b0, 8'h11, 1'b0);
      send(8'h00, 8'h22, 3'd7, 1'b0, 8'h22, 1'b0);
      fork
         send(8'h00, 8'h33, 3'd7, 1'b0, 8'h33, 1'b0);
         begin
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               chk("stall_in_ready",  32'(in_ready),  0);
               chk("stall_out_valid", 32'(out_valid), 1);
               chk("stall_out_data",  32'(out_data),  32'h11);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // acc_clr coincides with the S2 load of 0xAA
      send(8'h00, 8'hAA, 3'd7, 1'b0, 8'hAA, 1'b1);
      acc_clr = 1'b1;
      acc_model = ACC_INIT;
      send(8'h00, 8'h01, 3'd1, 1'b1, 8'h01, 1'b1);
      acc_clr = 1'b0;
      drain();

      // Popcount sample
      send(8'h00, 8'hB7, 3'd7, 1'b0, 8'hB7, 1'b1);
      drain();

      // Reset with two transactions in flight
      send(8'h5A, 8'h0F, 3'd2, 1'b0, -1, 1'b0);
      send(8'h5A, 8'hF0, 3'd2, 1'b0, -1, 1'b0);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      acc_model = ACC_INIT;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_out_valid", 32'(out_valid), 0);
         chk("post_rst_out_data",  32'(out_data),  0);
      end
      @(posedge clk);
      #1;
      send(8'hFF, 8'h00, 3'd1, 1'b1, -1, 1'b1);
      drain();

      // Randomized traffic with random backpressure
      clear_acc();
      rnd_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), -1, 1'b0);
         if ($urandom % 5 == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rnd_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_logic_unit_pipe
